// File: rtl/conv_pkg.sv
// Shared types and widths for the conv stream controller.
//  state_e        : controller FSM states
//  BEAT_W/WORD_W  : DMA beat width and packed 3x3 byte word width
//  BEATS_PER_WORD : beats needed to build one 72-bit word
//  RES_W          : conv result width
package conv_pkg;
  typedef enum logic [2:0] {IDLE, LD_W, LD_P, FIRE, WAIT_O, SEND} state_e;

  localparam int BEAT_W         = 32;
  localparam int WORD_W         = 72;
  localparam int BEATS_PER_WORD = 3;
  localparam int RES_W          = 32;
endpackage

// File: rtl/conv_stream_ctrl_beat_packer.sv
// beat_packer: 32->72 deserialiser.
//  clk, rst   : clock, async active-high reset
//  beat       : incoming 32-bit beat
//  beat_en    : beat accepted this cycle
//  word       : assembled word, valid in the cycle word_done is high
//  word_done  : pulse on the accepted beat that completes a word
// The final beat is not registered; word combines the two held beats with the
// live third beat, so the owner latches it on word_done. Bits [31:8] of the
// third beat are dropped.
module beat_packer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] beat,
  input  logic              beat_en,
  output logic [WORD_W-1:0] word,
  output logic              word_done
);
  localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_WORD - 1);

  logic [1:0]        cnt;
  logic [BEAT_W-1:0] b0, b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      b0  <= '0;
      b1  <= '0;
    end else if (beat_en) begin
      case (cnt)
        2'd0:    begin b0 <= beat; cnt <= 2'd1; end
        2'd1:    begin b1 <= beat; cnt <= 2'd2; end
        default: cnt <= '0;
      endcase
    end
  end

  assign word_done = beat_en && (cnt == LAST_BEAT);
  assign word      = {beat[7:0], b1, b0};
endmodule

// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: sequencer between the DMA streams and the 3x3 conv MAC.
//  s_axis_*      : MM2S input; one weight word then NUM_PATCH patch words
//  m_axis_*      : S2MM output; one 32-bit result per patch, tlast on the last
//  conv_w/_p     : held weight and patch words, *_valid pulse together for one cycle
//  conv_o(_valid): conv result and strobe; sampled RES_DLY cycles after the strobe
//  busy          : job in progress
//  err_tlast     : sticky, set on misplaced or missing MM2S tlast
// One job at a time. All outputs are registered.
module conv_stream_ctrl
  import conv_pkg::*;
#(
  parameter int NUM_PATCH = 16,
  parameter int RES_DLY   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [RES_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [WORD_W-1:0] conv_w,
  output logic              conv_w_valid,
  output logic [WORD_W-1:0] conv_p,
  output logic              conv_p_valid,
  input  logic [RES_W-1:0]  conv_o,
  input  logic              conv_o_valid,
  output logic              busy,
  output logic              err_tlast
);
  localparam int          PW       = $clog2(NUM_PATCH + 1);
  localparam logic [PW-1:0] LAST_P = PW'(NUM_PATCH - 1);
  localparam logic [1:0]  DLY_INIT = (RES_DLY > 0) ? 2'(RES_DLY - 1) : 2'd0;

  state_e            state;
  logic [PW-1:0]     patch_cnt;
  logic [1:0]        dly_cnt;
  logic              dly_act;   // strobe seen, counting down to the sample cycle
  logic              beat_en;
  logic [WORD_W-1:0] word;
  logic              word_done;
  logic              final_beat;
  logic              sample;

  assign beat_en = s_axis_tvalid && s_axis_tready;

  beat_packer u_pack (
    .clk       (clk),
    .rst       (rst),
    .beat      (s_axis_tdata),
    .beat_en   (beat_en),
    .word      (word),
    .word_done (word_done)
  );

  // The only beat allowed to carry tlast is the one completing the last patch.
  assign final_beat = word_done && (state == LD_P) && (patch_cnt == LAST_P);

  // With no delay the strobe cycle itself is the sample cycle.
  assign sample = (state == WAIT_O) &&
                  (dly_act ? (dly_cnt == 2'd0) : (conv_o_valid && (RES_DLY == 0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      patch_cnt     <= '0;
      dly_cnt       <= '0;
      dly_act       <= 1'b0;
      s_axis_tready <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      conv_w        <= '0;
      conv_w_valid  <= 1'b0;
      conv_p        <= '0;
      conv_p_valid  <= 1'b0;
      busy          <= 1'b0;
      err_tlast     <= 1'b0;
    end else begin
      conv_w_valid <= 1'b0;
      conv_p_valid <= 1'b0;
      if (beat_en && (s_axis_tlast != final_beat)) err_tlast <= 1'b1;

      case (state)
        IDLE: begin
          s_axis_tready <= 1'b1;
          if (beat_en) begin
            busy  <= 1'b1;
            state <= LD_W;
          end
        end
        LD_W: if (word_done) begin
          conv_w <= word;
          state  <= LD_P;
        end
        LD_P: if (word_done) begin
          conv_p        <= word;
          conv_w_valid  <= 1'b1;
          conv_p_valid  <= 1'b1;
          s_axis_tready <= 1'b0;
          state         <= FIRE;
        end
        FIRE: state <= WAIT_O;
        WAIT_O: begin
          if (sample) begin
            m_axis_tdata  <= conv_o;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (patch_cnt == LAST_P);
            dly_act       <= 1'b0;
            state         <= SEND;
          end else if (dly_act) begin
            dly_cnt <= dly_cnt - 2'd1;
          end else if (conv_o_valid) begin
            dly_act <= 1'b1;
            dly_cnt <= DLY_INIT;
          end
        end
        SEND: if (m_axis_tready) begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          s_axis_tready <= 1'b1;
          if (patch_cnt == LAST_P) begin
            patch_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            patch_cnt <= patch_cnt + PW'(1);
            state     <= LD_P;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Scoreboard bench for conv_stream_ctrl (NUM_PATCH=2, RES_DLY=2).
// Expected results are byte dot-products of the stimulus words; a conv model
// answers each fire with a random-latency strobe and a conv_o that changes
// every cycle, only the RES_DLY-th value being the true product.
module tb_conv_stream_ctrl;
  localparam int NP = 2;
  localparam int RD = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic [71:0] conv_w;
  logic        conv_w_valid;
  logic [71:0] conv_p;
  logic        conv_p_valid;
  logic [31:0] conv_o = '0;
  logic        conv_o_valid = 1'b0;
  logic        busy;
  logic        err_tlast;

  int   vecs = 0;
  int   errs = 0;
  res_t exp_q[$];
  logic [71:0] wq[$];
  logic [71:0] pq[$];
  logic [71:0] pat[NP];
  logic exp_err = 1'b0;
  int   hold_req = 0;

  conv_stream_ctrl #(.NUM_PATCH(NP), .RES_DLY(RD)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .conv_w(conv_w), .conv_w_valid(conv_w_valid),
    .conv_p(conv_p), .conv_p_valid(conv_p_valid),
    .conv_o(conv_o), .conv_o_valid(conv_o_valid),
    .busy(busy), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dot(input logic [71:0] w, input logic [71:0] p);
    logic [31:0] s = '0;
    for (int i = 0; i < 9; i++) s += 32'(w[8*i +: 8]) * 32'(p[8*i +: 8]);
    return s;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic die(input string why);
    errs++;
    $display("FAIL %s: bound expired at %0t", why, $time);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $fatal(1, "bench aborted");
  endtask

  // Called at a negedge; returns at the negedge after the beat is taken.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int to = 0;
    if ($urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    while (!s_tready) begin
      @(negedge clk);
      if (++to > 500) die("s_handshake");
    end
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic send_word(input logic [71:0] wd, input int base, input int bad_at,
                           input bit final_tl);
    int last = 3 * (NP + 1) - 1;
    logic [31:0] g;
    logic [31:0] b;
    for (int k = 0; k < 3; k++) begin
      g = $urandom;
      b = (k == 0) ? wd[31:0] : (k == 1) ? wd[63:32] : {g[23:0], wd[71:64]};
      send_beat(b, ((base + k) == bad_at) || (((base + k) == last) && final_tl));
    end
  endtask

  task automatic run_job(input logic [71:0] w, input int bad_at, input bit final_tl);
    int last = 3 * (NP + 1) - 1;
    int to = 0;
    if ((bad_at >= 0 && bad_at != last) || !final_tl) exp_err = 1'b1;
    for (int i = 0; i < NP; i++) begin
      exp_q.push_back('{data: dot(w, pat[i]), last: (i == NP - 1)});
      wq.push_back(w);
      pq.push_back(pat[i]);
    end
    send_word(w, 0, bad_at, final_tl);
    for (int i = 0; i < NP; i++) send_word(pat[i], 3 * (i + 1), bad_at, final_tl);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      if (++to > 3000) die("job_done");
    end
    repeat (2) @(negedge clk);
    check("busy_after_job", 72'(busy), 72'(1'b0));
    check("err_tlast", 72'(err_tlast), 72'(exp_err));
  endtask

  task automatic rand_pat();
    for (int i = 0; i < NP; i++) pat[i] = {$urandom, $urandom, $urandom};
  endtask

  // Output monitor: drives m_tready, checks stalls and pops the scoreboard.
  initial begin
    res_t e;
    logic prev_stall = 1'b0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_tready = 1'b0;
        prev_stall = 1'b0;
        continue;
      end
      if (prev_stall) begin
        check("stall_valid", 72'(m_tvalid), 72'(1'b1));
        check("stall_data", 72'({m_tdata, m_tlast}), 72'({pd, pl}));
      end
      if (m_tvalid) begin
        check("s_ready_in_send", 72'(s_tready), 72'(1'b0));
        if (hold_req > 0) begin
          m_tready = 1'b0;
          hold_req--;
        end else begin
          m_tready = ($urandom_range(0, 3) != 0);
        end
        if (m_tready) begin
          if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_result: got %0h expected none", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("result", 72'({m_tdata, m_tlast}), 72'({e.data, e.last}));
          end
        end
        prev_stall = !m_tready;
        pd = m_tdata;
        pl = m_tlast;
      end else begin
        m_tready = 1'($urandom_range(0, 1));
        prev_stall = 1'b0;
      end
    end
  end

  // Conv model: answers each fire; drops spurious strobes when not pending.
  initial begin
    logic [31:0] d;
    logic [71:0] ew, ep;
    forever begin
      @(negedge clk);
      conv_o_valid = 1'b0;
      conv_o = $urandom;
      if (rst) continue;
      if (conv_p_valid) begin
        check("w_valid_with_p", 72'(conv_w_valid), 72'(1'b1));
        if (wq.size() == 0) begin
          errs++;
          $display("FAIL unexpected_fire: got %0h expected none", conv_p);
        end else begin
          ew = wq.pop_front();
          ep = pq.pop_front();
          check("conv_w", conv_w, ew);
          check("conv_p", conv_p, ep);
        end
        d = dot(conv_w, conv_p);
        @(negedge clk);
        check("fire_pulse_width", 72'({conv_w_valid, conv_p_valid}), 72'(2'b00));
        conv_o = $urandom;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          conv_o = $urandom;
        end
        conv_o_valid = 1'b1;
        conv_o = d + 32'd1;
        for (int k = 1; k <= RD; k++) begin
          @(negedge clk);
          conv_o_valid = 1'b0;
          conv_o = (k == RD) ? d : d + 32'(k) + 32'd1;
        end
      end else if (conv_w_valid) begin
        check("w_valid_alone", 72'(conv_w_valid), 72'(1'b0));
      end else if ($urandom_range(0, 5) == 0) begin
        conv_o_valid = 1'b1;
      end
    end
  end

  initial begin
    #2000000;
    die("watchdog");
  end

  initial begin
    logic [71:0] w;
    logic [71:0] tmp;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 72'(s_tready), 72'(1'b0));
    check("rst_m_valid", 72'(m_tvalid), 72'(1'b0));
    check("rst_busy_err", 72'({busy, err_tlast}), 72'(2'b00));
    check("rst_conv", {conv_w[70:0], conv_p_valid}, 72'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_s_ready", 72'(s_tready), 72'(1'b1));

    // all ones: two results of 9
    w = {9{8'h01}};
    for (int i = 0; i < NP; i++) pat[i] = {9{8'h01}};
    run_job(w, -1, 1'b1);

    // weights 1..9, patch all 2 -> 90
    w = 72'h090807060504030201;
    for (int i = 0; i < NP; i++) pat[i] = {9{8'h02}};
    run_job(w, -1, 1'b1);

    for (int j = 0; j < 6; j++) begin
      if (j == 2) hold_req = 20;
      rand_pat();
      w = {$urandom, $urandom, $urandom};
      run_job(w, -1, 1'b1);
    end

    // tlast on beat 3 (last weight beat); sticky across a clean job
    rand_pat();
    w = {$urandom, $urandom, $urandom};
    run_job(w, 2, 1'b1);
    rand_pat();
    run_job(w, -1, 1'b1);

    // reset mid-job, after the first patch beat
    tmp = {$urandom, $urandom, $urandom};
    send_word(tmp, 0, -1, 1'b0);
    send_beat($urandom, 1'b0);
    check("busy_mid_job", 72'(busy), 72'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("midrst_ready_valid", 72'({s_tready, m_tvalid}), 72'(2'b00));
    check("midrst_busy_err", 72'({busy, err_tlast}), 72'(2'b00));
    check("midrst_conv_w", conv_w, 72'(0));
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int j = 0; j < 3; j++) begin
      rand_pat();
      w = {$urandom, $urandom, $urandom};
      run_job(w, -1, 1'b1);
    end

    // missing tlast on the final beat
    rand_pat();
    w = {$urandom, $urandom, $urandom};
    run_job(w, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
